// File: rtl/sram_port_arbiter.sv
// Round-robin owner of the single SRAM port: burst-locked grants with a starvation cap,
// registered SRAM commands and in-order routing of read data back to the issuing requester.
module sram_port_arbiter #(
  parameter int ADDR_SIZE  = 10,
  parameter int WORD_SIZE  = 16,
  parameter int NUM_REQ    = 3,
  parameter int MAX_BURST  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0]                  req_last,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [WORD_SIZE-1:0]                rsp_data,
  output logic                                mem_en,
  output logic                                mem_we,
  output logic [ADDR_SIZE-1:0]                mem_addr,
  output logic [WORD_SIZE-1:0]                mem_wdata,
  input  logic [WORD_SIZE-1:0]                mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                busy,
  output logic                                state_dbg
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_BURST);

  // Handshake: a beat transfers in a cycle where req_valid[i] and req_ready[i] are both high;
  // req_ready is only ever raised for the current owner in GRANT and follows its req_valid.

  logic [0:0]           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [IDW-1:0]       mem_id_q, mem_id_d;

  logic [RD_LATENCY-1:0]          pipe_v_q;
  logic [RD_LATENCY-1:0][IDW-1:0] pipe_id_q;
  logic [RD_LATENCY:0]            pipe_v_ext;
  logic [RD_LATENCY:0][IDW-1:0]   pipe_id_ext;
  logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0]           rsp_data_q, rsp_data_d;

  logic                 pick_found;
  logic [IDW-1:0]       pick_id;
  logic [IDW:0]         idx_ext;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [NUM_REQ-1:0]   ready_c;
  logic                 accept;
  logic                 others_pending;
  logic [CW-1:0]        cnt_inc;
  logic                 release_c;
  logic                 ret_v;
  logic [IDW-1:0]       ret_id;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx_ext    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_ext = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx_ext >= NUM_REQ_W) idx_ext = idx_ext - NUM_REQ_W;
      if (!pick_found && req_valid[idx_ext[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx_ext[IDW-1:0];
      end
    end
  end

  assign grant_oh       = NUM_REQ'(1) << grant_q;
  assign ready_c        = (state_q == ST_GRANT) ? (req_valid & grant_oh) : '0;
  assign accept         = |ready_c;
  assign others_pending = |(req_valid & ~grant_oh);
  assign cnt_inc        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // The cap only bites when someone else is waiting; a lone owner streams indefinitely.
  assign release_c = (accept && req_last[grant_q]) || !req_valid[grant_q] ||
                     (accept && (cnt_inc == CNT_MAX) && others_pending);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_id_d    = mem_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = pick_id;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          mem_en_d    = 1'b1;
          mem_we_d    = req_we[grant_q];
          mem_addr_d  = req_addr[grant_q];
          mem_wdata_d = req_wdata[grant_q];
          mem_id_d    = grant_q;
          cnt_d       = cnt_inc;
        end
        if (release_c) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read return: {valid,id} travels alongside the SRAM latency, data is registered once more.
  assign pipe_v_ext  = {pipe_v_q, mem_en_q & ~mem_we_q};
  assign pipe_id_ext = {pipe_id_q, mem_id_q};
  assign ret_v       = pipe_v_q[RD_LATENCY-1];
  assign ret_id      = pipe_id_q[RD_LATENCY-1];
  assign rsp_valid_d = ret_v ? (NUM_REQ'(1) << ret_id) : '0;
  assign rsp_data_d  = ret_v ? mem_rdata : rsp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_id_q    <= '0;
      pipe_v_q    <= '0;
      pipe_id_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_id_q    <= mem_id_d;
      pipe_v_q    <= pipe_v_ext[RD_LATENCY-1:0];
      pipe_id_q   <= pipe_id_ext[RD_LATENCY-1:0];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_GRANT);
  assign state_dbg = state_q;

endmodule
